uart_intr_ctrl: RTL and testbench

//  16550-style interrupt arbiter/scheduler for the UART. Sits beside the register block and the TX/RX FIFOs.

---
 rtl/uart_intr_ctrl_if.sv | 33 +++
 rtl/uart_intr_ctrl.sv | 111 +++++++++++
 tb/tb_uart_intr_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_intr_ctrl_if.sv
// Signal bundle between the UART register/FIFO side and the interrupt controller.
// The register block is the master; the interrupt controller is the slave.
interface uart_intr_ctrl_if;
    logic       baud_pulse_i;
    logic [3:0] ier_i;
    logic [1:0] wls_i;
    logic       pen_i;
    logic       stb_i;
    logic       ls_err_i;
    logic [4:0] rx_level_i;
    logic [4:0] rx_trig_i;
    logic       rx_push_i;
    logic       rx_pop_i;
    logic       thr_empty_i;
    logic       thr_write_i;
    logic       msr_delta_i;
    logic       iir_read_i;
    logic       intr_o;
    logic [3:0] iir_o;
    logic       cti_o;

    modport master (
        output baud_pulse_i, ier_i, wls_i, pen_i, stb_i, ls_err_i, rx_level_i, rx_trig_i,
               rx_push_i, rx_pop_i, thr_empty_i, thr_write_i, msr_delta_i, iir_read_i,
        input  intr_o, iir_o, cti_o
    );

    modport slave (
        input  baud_pulse_i, ier_i, wls_i, pen_i, stb_i, ls_err_i, rx_level_i, rx_trig_i,
               rx_push_i, rx_pop_i, thr_empty_i, thr_write_i, msr_delta_i, iir_read_i,
        output intr_o, iir_o, cti_o
    );
endinterface

// File: rtl/uart_intr_ctrl.sv
// 16550-style interrupt prioritiser: gates the four sources by IER, registers the
// winning IIR code and the interrupt line, and owns the character-timeout counter.
module uart_intr_ctrl #(
    parameter int unsigned TO_CHARS = 4,
    parameter int unsigned CNT_W    = 10
) (
    input logic             clk,
    input logic             rst,
    uart_intr_ctrl_if.slave bus
);

    localparam logic [3:0] IirRls  = 4'b0110;
    localparam logic [3:0] IirRda  = 4'b0100;
    localparam logic [3:0] IirCti  = 4'b1100;
    localparam logic [3:0] IirThre = 4'b0010;
    localparam logic [3:0] IirMs   = 4'b0000;
    localparam logic [3:0] IirNone = 4'b0001;

    logic             thr_empty_q;
    logic             etbei_q;
    logic             thre_pend_q, thre_pend_d;
    logic             cti_flag_q, cti_flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       iir_q, iir_d;
    logic             intr_q;

    logic [3:0]       char_bits;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] cnt_inc;
    logic             rx_clr;
    logic             thre_set;
    logic             thre_clr;

    // Timeout limit in 16x ticks: TO_CHARS frames of start+data+parity+stop bits.
    always_comb begin
        char_bits = 4'd7 + {2'b00, bus.wls_i} + {3'b000, bus.pen_i} + {3'b000, bus.stb_i};
        limit     = CNT_W'(TO_CHARS * 16 * 32'(char_bits));
    end

    // Character-timeout counter: restarts on any RX activity or empty FIFO, saturates at limit.
    always_comb begin
        cnt_d      = cnt_q;
        cti_flag_d = cti_flag_q;
        cnt_inc    = (cnt_q < limit) ? cnt_q + 1'b1 : cnt_q;
        rx_clr     = (bus.rx_level_i == 5'd0) | bus.rx_push_i | bus.rx_pop_i;
        if (rx_clr) begin
            cnt_d      = '0;
            cti_flag_d = 1'b0;
        end else if (bus.baud_pulse_i) begin
            cnt_d = cnt_inc;
            // Compared only on a tick, so a config change takes effect at the next tick.
            if (cnt_inc >= limit) begin
                cti_flag_d = 1'b1;
            end
        end
    end

    // THRE pending: set on empty edge or ETBEI enable while empty; clear has priority.
    always_comb begin
        thre_set    = (bus.thr_empty_i & ~thr_empty_q) | (bus.ier_i[1] & ~etbei_q & bus.thr_empty_i);
        thre_clr    = bus.thr_write_i | (bus.iir_read_i & (iir_q == IirThre));
        thre_pend_d = thre_pend_q;
        if (thre_clr) begin
            thre_pend_d = 1'b0;
        end else if (thre_set) begin
            thre_pend_d = 1'b1;
        end
    end

    // Priority select; internal sources use next state so IIR follows them by one clock.
    always_comb begin
        iir_d = IirNone;
        if (bus.ier_i[2] & bus.ls_err_i) begin
            iir_d = IirRls;
        end else if (bus.ier_i[0] & (bus.rx_level_i >= bus.rx_trig_i)) begin
            iir_d = IirRda;
        end else if (bus.ier_i[0] & cti_flag_d) begin
            iir_d = IirCti;
        end else if (bus.ier_i[1] & thre_pend_d) begin
            iir_d = IirThre;
        end else if (bus.ier_i[3] & bus.msr_delta_i) begin
            iir_d = IirMs;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr_empty_q <= 1'b1;
            etbei_q     <= 1'b0;
            thre_pend_q <= 1'b0;
            cti_flag_q  <= 1'b0;
            cnt_q       <= '0;
            iir_q       <= IirNone;
            intr_q      <= 1'b0;
        end else begin
            thr_empty_q <= bus.thr_empty_i;
            etbei_q     <= bus.ier_i[1];
            thre_pend_q <= thre_pend_d;
            cti_flag_q  <= cti_flag_d;
            cnt_q       <= cnt_d;
            iir_q       <= iir_d;
            intr_q      <= ~iir_d[0];
        end
    end

    assign bus.intr_o = intr_q;
    assign bus.iir_o  = iir_q;
    assign bus.cti_o  = cti_flag_q;

endmodule

// File: tb/tb_uart_intr_ctrl.sv
// Self-checking bench for uart_intr_ctrl: directed sequences, a priority vector table
// and randomized traffic checked against a behavioural model.
module tb_uart_intr_ctrl;

    localparam int TO_CHARS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_intr_ctrl_if bus ();

    uart_intr_ctrl #(
        .TO_CHARS(TO_CHARS),
        .CNT_W   (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state.
    logic       m_pend;
    int         m_idle;
    logic       m_cti;
    logic [3:0] m_iir;
    logic       m_prev_empty;
    logic       m_prev_etbei;

    typedef struct {
        logic [3:0] ier;
        logic       ls;
        logic [4:0] lvl;
        logic [4:0] trig;
        logic       empty;
        logic       write;
        logic       msr;
        logic [3:0] exp_iir;
    } vec_t;

    vec_t vecs [12];
    logic [4:0] trigs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic m_reset();
        m_pend       = 1'b0;
        m_idle       = 0;
        m_cti        = 1'b0;
        m_iir        = 4'b0001;
        m_prev_empty = 1'b1;
        m_prev_etbei = 1'b0;
    endtask

    // One clock: predict from current inputs, advance, then compare all outputs.
    task automatic tick();
        int         bits;
        int         limit;
        int         n_idle;
        logic       n_pend;
        logic       n_cti;
        logic       set;
        logic       clr;
        logic [3:0] n_iir;
        n_idle = m_idle;
        n_pend = m_pend;
        n_cti  = m_cti;
        n_iir  = m_iir;
        if (rst) begin
            bits  = 7 + int'(bus.wls_i) + int'(bus.pen_i) + int'(bus.stb_i);
            limit = TO_CHARS * 16 * bits;
            set = (bus.thr_empty_i && !m_prev_empty) ||
                  (bus.ier_i[1] && !m_prev_etbei && bus.thr_empty_i);
            clr = bus.thr_write_i || (bus.iir_read_i && m_iir == 4'b0010);
            if (clr) n_pend = 1'b0;
            else if (set) n_pend = 1'b1;
            if (bus.rx_level_i == 0 || bus.rx_push_i || bus.rx_pop_i) begin
                n_idle = 0;
                n_cti  = 1'b0;
            end else if (bus.baud_pulse_i) begin
                if (n_idle < limit) n_idle++;
                if (n_idle >= limit) n_cti = 1'b1;
            end
            if (bus.ier_i[2] && bus.ls_err_i) n_iir = 4'b0110;
            else if (bus.ier_i[0] && bus.rx_level_i >= bus.rx_trig_i) n_iir = 4'b0100;
            else if (bus.ier_i[0] && n_cti) n_iir = 4'b1100;
            else if (bus.ier_i[1] && n_pend) n_iir = 4'b0010;
            else if (bus.ier_i[3] && bus.msr_delta_i) n_iir = 4'b0000;
            else n_iir = 4'b0001;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_prev_empty = bus.thr_empty_i;
            m_prev_etbei = bus.ier_i[1];
            m_pend = n_pend;
            m_idle = n_idle;
            m_cti  = n_cti;
            m_iir  = n_iir;
        end else begin
            m_reset();
        end
        chk("model_iir", 32'(bus.iir_o), 32'(m_iir));
        chk("model_intr", 32'(bus.intr_o), 32'(!m_iir[0]));
        chk("model_cti", 32'(bus.cti_o), 32'(m_cti));
    endtask

    initial begin
        bus.baud_pulse_i = 1'b0;
        bus.ier_i        = 4'b0000;
        bus.wls_i        = 2'd3;
        bus.pen_i        = 1'b0;
        bus.stb_i        = 1'b0;
        bus.ls_err_i     = 1'b0;
        bus.rx_level_i   = 5'd0;
        bus.rx_trig_i    = 5'd1;
        bus.rx_push_i    = 1'b0;
        bus.rx_pop_i     = 1'b0;
        bus.thr_empty_i  = 1'b0;
        bus.thr_write_i  = 1'b0;
        bus.msr_delta_i  = 1'b0;
        bus.iir_read_i   = 1'b0;

        trigs[0] = 5'd1; trigs[1] = 5'd4; trigs[2] = 5'd8; trigs[3] = 5'd14;

        //          ier      ls    lvl    trig   empty write msr   iir
        vecs[0]  = '{4'b1111, 1'b1, 5'd4,  5'd4,  1'b1, 1'b0, 1'b1, 4'b0110};
        vecs[1]  = '{4'b1111, 1'b0, 5'd4,  5'd4,  1'b1, 1'b0, 1'b1, 4'b0100};
        vecs[2]  = '{4'b1111, 1'b0, 5'd3,  5'd4,  1'b1, 1'b0, 1'b1, 4'b0010};
        vecs[3]  = '{4'b1111, 1'b0, 5'd3,  5'd4,  1'b1, 1'b1, 1'b1, 4'b0000};
        vecs[4]  = '{4'b1111, 1'b0, 5'd3,  5'd4,  1'b1, 1'b0, 1'b0, 4'b0001};
        vecs[5]  = '{4'b0000, 1'b1, 5'd4,  5'd4,  1'b1, 1'b0, 1'b1, 4'b0001};
        vecs[6]  = '{4'b1000, 1'b1, 5'd4,  5'd4,  1'b1, 1'b0, 1'b1, 4'b0000};
        vecs[7]  = '{4'b0100, 1'b1, 5'd4,  5'd4,  1'b1, 1'b0, 1'b1, 4'b0110};
        vecs[8]  = '{4'b0001, 1'b0, 5'd16, 5'd14, 1'b1, 1'b0, 1'b1, 4'b0100};
        vecs[9]  = '{4'b0010, 1'b0, 5'd0,  5'd4,  1'b1, 1'b0, 1'b1, 4'b0010};
        vecs[10] = '{4'b1010, 1'b0, 5'd0,  5'd4,  1'b1, 1'b0, 1'b1, 4'b0010};
        vecs[11] = '{4'b1010, 1'b0, 5'd0,  5'd4,  1'b0, 1'b1, 1'b1, 4'b0000};

        // Reset state.
        #2 rst = 1'b0;
        #1;
        m_reset();
        chk("reset_iir", 32'(bus.iir_o), 32'h1);
        chk("reset_intr", 32'(bus.intr_o), 32'h0);
        chk("reset_cti", 32'(bus.cti_o), 32'h0);
        tick();
        tick();
        #3 rst = 1'b1;

        // THRE on empty edge, cleared by IIR read.
        bus.ier_i = 4'b0010;
        tick();
        chk("thre_idle", 32'(bus.iir_o), 32'h1);
        bus.thr_empty_i = 1'b1;
        tick();
        chk("thre_set_iir", 32'(bus.iir_o), 32'h2);
        chk("thre_set_intr", 32'(bus.intr_o), 32'h1);
        bus.iir_read_i = 1'b1;
        tick();
        bus.iir_read_i = 1'b0;
        chk("thre_read_iir", 32'(bus.iir_o), 32'h1);
        chk("thre_read_intr", 32'(bus.intr_o), 32'h0);

        // Write coincident with empty edge: clear wins; ETBEI enable while empty sets.
        bus.thr_empty_i = 1'b0;
        tick();
        bus.thr_empty_i = 1'b1;
        bus.thr_write_i = 1'b1;
        tick();
        bus.thr_write_i = 1'b0;
        chk("thre_clr_wins", 32'(bus.iir_o), 32'h1);
        tick();
        chk("thre_clr_hold", 32'(bus.iir_o), 32'h1);
        bus.ier_i = 4'b0000;
        tick();
        bus.ier_i = 4'b0010;
        tick();
        chk("thre_etbei_edge", 32'(bus.iir_o), 32'h2);
        bus.thr_write_i = 1'b1;
        tick();
        bus.thr_write_i = 1'b0;
        chk("thre_write_clr", 32'(bus.iir_o), 32'h1);

        // RDA at trigger level, gone below it.
        bus.ier_i = 4'b0001;
        bus.rx_trig_i = 5'd4;
        for (int l = 1; l <= 4; l++) begin
            bus.rx_level_i = 5'(l);
            bus.rx_push_i  = 1'b1;
            tick();
            if (l == 3) chk("rda_below", 32'(bus.iir_o), 32'h1);
        end
        bus.rx_push_i = 1'b0;
        chk("rda_at_trig", 32'(bus.iir_o), 32'h4);
        bus.rx_level_i = 5'd3;
        bus.rx_pop_i   = 1'b1;
        tick();
        bus.rx_pop_i = 1'b0;
        chk("rda_pop", 32'(bus.iir_o), 32'h1);

        // Character timeout: 10-bit frames -> 640 ticks.
        bus.rx_level_i = 5'd1;
        bus.rx_push_i  = 1'b1;
        tick();
        bus.rx_push_i = 1'b0;
        for (int i = 1; i <= 640; i++) begin
            bus.baud_pulse_i = 1'b1;
            tick();
            bus.baud_pulse_i = 1'b0;
            if (i == 639) chk("cti_639", 32'(bus.cti_o), 32'h0);
            if (i == 640) begin
                chk("cti_640", 32'(bus.cti_o), 32'h1);
                chk("cti_640_iir", 32'(bus.iir_o), 32'hC);
            end
            tick();
        end
        bus.rx_pop_i = 1'b1;
        tick();
        bus.rx_pop_i = 1'b0;
        chk("cti_pop_clr", 32'(bus.cti_o), 32'h0);
        chk("cti_pop_iir", 32'(bus.iir_o), 32'h1);
        bus.rx_level_i = 5'd0;
        bus.thr_empty_i = 1'b0;
        bus.ier_i = 4'b0000;
        tick();
        tick();

        // Priority table.
        for (int v = 0; v < 12; v++) begin
            bus.ier_i       = vecs[v].ier;
            bus.ls_err_i    = vecs[v].ls;
            bus.rx_level_i  = vecs[v].lvl;
            bus.rx_trig_i   = vecs[v].trig;
            bus.thr_empty_i = vecs[v].empty;
            bus.thr_write_i = vecs[v].write;
            bus.msr_delta_i = vecs[v].msr;
            tick();
            bus.thr_write_i = 1'b0;
            tick();
            chk($sformatf("vec%0d_iir", v), 32'(bus.iir_o), 32'(vecs[v].exp_iir));
        end

        // Async reset mid-count, then full timeout from zero, then idle FIFO stays quiet.
        bus.ier_i       = 4'b1001;
        bus.ls_err_i    = 1'b0;
        bus.msr_delta_i = 1'b1;
        bus.rx_trig_i   = 5'd4;
        bus.rx_level_i  = 5'd1;
        bus.rx_push_i   = 1'b1;
        tick();
        bus.rx_push_i    = 1'b0;
        bus.baud_pulse_i = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        bus.baud_pulse_i = 1'b0;
        chk("pre_rst_iir", 32'(bus.iir_o), 32'h0);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_iir", 32'(bus.iir_o), 32'h1);
        chk("async_rst_intr", 32'(bus.intr_o), 32'h0);
        chk("async_rst_cti", 32'(bus.cti_o), 32'h0);
        m_reset();
        #2 rst = 1'b1;
        bus.baud_pulse_i = 1'b1;
        for (int i = 1; i <= 640; i++) begin
            tick();
            if (i == 639) chk("post_rst_639", 32'(bus.cti_o), 32'h0);
            if (i == 640) chk("post_rst_640", 32'(bus.iir_o), 32'hC);
        end
        bus.rx_level_i = 5'd0;
        for (int i = 0; i < 800; i++) tick();
        chk("idle_no_cti", 32'(bus.cti_o), 32'h0);
        bus.baud_pulse_i = 1'b0;
        bus.msr_delta_i  = 1'b0;

        // Randomized traffic against the model.
        for (int s = 0; s < 6; s++) begin
            bus.wls_i      = 2'($urandom_range(0, 3));
            bus.pen_i      = 1'($urandom_range(0, 1));
            bus.stb_i      = 1'($urandom_range(0, 1));
            bus.rx_trig_i  = trigs[$urandom_range(0, 3)];
            bus.rx_level_i = 5'($urandom_range(0, 16));
            bus.ier_i      = 4'($urandom);
            for (int c = 0; c < 1100; c++) begin
                bus.baud_pulse_i = ($urandom_range(0, 3) != 0);
                bus.rx_push_i    = 1'b0;
                bus.rx_pop_i     = 1'b0;
                if ($urandom_range(0, 399) == 0 && bus.rx_level_i < 5'd16) begin
                    bus.rx_push_i  = 1'b1;
                    bus.rx_level_i = bus.rx_level_i + 5'd1;
                end else if ($urandom_range(0, 399) == 0 && bus.rx_level_i > 5'd0) begin
                    bus.rx_pop_i   = 1'b1;
                    bus.rx_level_i = bus.rx_level_i - 5'd1;
                end
                if ($urandom_range(0, 59) == 0) bus.ls_err_i = ~bus.ls_err_i;
                if ($urandom_range(0, 59) == 0) bus.msr_delta_i = ~bus.msr_delta_i;
                if ($urandom_range(0, 24) == 0) bus.thr_empty_i = ~bus.thr_empty_i;
                bus.thr_write_i = ($urandom_range(0, 39) == 0);
                bus.iir_read_i  = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 299) == 0) bus.ier_i = 4'($urandom);
                if ($urandom_range(0, 349) == 0) bus.wls_i = 2'($urandom_range(0, 3));
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
